// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one byte-wide UART transmitter among NUM_REQ requesters. Requesters
// are granted round-robin, one byte per grant, and the transmitter is
// sequenced over a start/busy handshake.
//
// Optional feature (compile-time macro UART_ARB_SRC_HDR_EN):
//   When defined, every grant first sends a header byte {5'b10100, grant_id}
//   (grant_id zero-padded to 3 bits), then the captured data byte.
//   When undefined, exactly one byte is sent per grant.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ-1:0]   per-requester byte valid
//   req_data   in   [8*NUM_REQ-1:0] requester i byte on [8*i+7:8*i]
//   req_ready  out  [NUM_REQ-1:0]   one-hot accept pulse, byte captured that cycle
//   tx_data    out  [7:0]           byte to transmitter, stable for the frame
//   tx_start   out  1-cycle launch pulse to transmitter
//   tx_busy    in   transmitter busy, high for the whole frame
//   grant_id   out  [ID_W-1:0]      index of requester currently served
//   arb_busy   out  high in every state except IDLE
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 arb_busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GRANT   = 3'd1;
`ifdef UART_ARB_SRC_HDR_EN
  localparam logic [2:0] HDR     = 3'd2;
`endif
  localparam logic [2:0] LAUNCH  = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] WAIT_LO = 3'd5;

  logic [2:0]      state;
  logic [ID_W-1:0] rr_ptr;

  logic            found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] rr_next;
  logic [7:0]      win_byte;

`ifdef UART_ARB_SRC_HDR_EN
  logic [7:0]      data_q;
  logic            hdr_pend;
  logic [7:0]      hdr_byte;

  assign hdr_byte = {5'b10100, 3'(grant_id)};
`endif

  // Round-robin scan: first valid index at or after rr_ptr, wrapping modulo
  // NUM_REQ (NUM_REQ need not be a power of two, hence the explicit wrap).
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!found && req_valid[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign rr_next  = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
  assign win_byte = req_data[{win_idx, 3'b000} +: 8];

  // req_ready and tx_start are decoded from state so each is exactly one
  // cycle wide: GRANT and the launching LAUNCH cycle both always exit.
  assign req_ready = (state == GRANT && found) ? (NUM_REQ'(1) << win_idx) : '0;
  assign tx_start  = (state == LAUNCH) && !tx_busy;
  assign arb_busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      tx_data  <= 8'h00;
`ifdef UART_ARB_SRC_HDR_EN
      data_q   <= 8'h00;
      hdr_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) state <= GRANT;
        end
        GRANT: begin
          // All requesters may have withdrawn since IDLE; go back quietly.
          if (found) begin
            grant_id <= win_idx;
            rr_ptr   <= rr_next;
`ifdef UART_ARB_SRC_HDR_EN
            data_q   <= win_byte;
            state    <= HDR;
`else
            tx_data  <= win_byte;
            state    <= LAUNCH;
`endif
          end else begin
            state <= IDLE;
          end
        end
`ifdef UART_ARB_SRC_HDR_EN
        HDR: begin
          tx_data  <= hdr_byte;
          hdr_pend <= 1'b1;
          state    <= LAUNCH;
        end
`endif
        LAUNCH: begin
          if (!tx_busy) state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
`ifdef UART_ARB_SRC_HDR_EN
            // Header frame finished: send the captured data byte next.
            if (hdr_pend) begin
              tx_data  <= data_q;
              hdr_pend <= 1'b0;
              state    <= LAUNCH;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Scoreboard bench for uart_tx_arbiter. Requesters are queues of bytes that
// hold valid/data until accepted. A reference model applies the round-robin
// rule to each grant and pushes the expected transmitter bytes; a separate
// monitor pops them on every tx_start. A small transmitter model answers
// tx_start with a 10-cycle busy frame. Header mode follows
// UART_ARB_SRC_HDR_EN, same as the design.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           arb_busy;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy)
  );

`ifdef UART_ARB_SRC_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pend [N][$];
  logic [7:0] exp_data [$];
  int         exp_id [$];
  int         grant_log [$];
  int         model_ptr = 0;
  int         tx_start_count = 0;
  int         ready_count = 0;

  int busy_cnt   = 0;
  bit stuck      = 1'b0;
  bit start_seen = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] data);
    pend[idx].push_back(data);
  endtask

  // Requester driver: keeps each requester's head byte presented until the
  // accept pulse, changing inputs only after the capturing edge.
  initial begin : driver
    logic [N-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        req_valid[i] = (pend[i].size() > 0);
        if (pend[i].size() > 0) req_data[8*i +: 8] = pend[i][0];
      end
    end
  end

  // Transmitter model: a tx_start launches a 10-cycle busy frame; 'stuck'
  // forces busy high independently.
  initial begin : tx_model
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) busy_cnt--;
      if (start_seen) begin
        busy_cnt   = 10;
        start_seen = 1'b0;
      end
      tx_busy = stuck || (busy_cnt > 0);
    end
  end

  // Reference model on each accept: first valid requester at or after the
  // model pointer wins; its byte (with header first, when enabled) is queued.
  initial begin : grant_monitor
    int  exp_idx;
    bit  exp_found;
    forever begin
      @(negedge clk);
      if (rst_n && req_ready != '0) begin
        exp_found = 1'b0;
        exp_idx   = 0;
        for (int k = 0; k < N; k++) begin
          if (!exp_found && req_valid[(model_ptr + k) % N]) begin
            exp_found = 1'b1;
            exp_idx   = (model_ptr + k) % N;
          end
        end
        ready_count++;
        checkOutput("grant_onehot", 32'(req_ready),
                    exp_found ? (32'd1 << exp_idx) : 32'd0);
        if (exp_found) begin
          grant_log.push_back(exp_idx);
          model_ptr = (exp_idx + 1) % N;
          if (HDR_EN) begin
            exp_data.push_back({5'b10100, 3'(exp_idx)});
            exp_id.push_back(exp_idx);
          end
          exp_data.push_back(req_data[8*exp_idx +: 8]);
          exp_id.push_back(exp_idx);
        end
      end
    end
  end

  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_start_count++;
        start_seen = 1'b1;
        checkOutput("start_while_busy", 32'(tx_busy), 32'd0);
        if (exp_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_tx_start: got tx_data %0h, expected no frame", tx_data);
        end else begin
          checkOutput("tx_data", 32'(tx_data), 32'(exp_data.pop_front()));
          checkOutput("tx_grant_id", 32'(grant_id), 32'(exp_id.pop_front()));
        end
      end
    end
  end

  task automatic waitIdle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (req_valid == '0) && (exp_data.size() == 0) && !arb_busy &&
             (busy_cnt == 0) && !tx_busy;
      for (int i = 0; i < N; i++) if (pend[i].size() > 0) done = 1'b0;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  task automatic waitTxStart(input int start_ref, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = (tx_start_count > start_ref);
    end
    checkOutput("tx_start_seen", 32'(seen), 32'd1);
  endtask

  task automatic checkLog(input string name, input int exp_q [$]);
    checkOutput({name, "_len"}, 32'(grant_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++) begin
      checkOutput(name, 32'(grant_log[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin : main
    int starts0;
    int readies0;
    int stuck_starts;
    int mask;
    int exp_q [$];

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_tx_start", 32'(tx_start), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'h00);
    checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset_arb_busy", 32'(arb_busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester, latency from valid to accept and launch.
    applyStimulus(0, 8'h55);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_req_ready", 32'(req_ready), 32'b0001);
    if (HDR_EN) @(negedge clk);
    @(negedge clk);
    checkOutput("latency_tx_start", 32'(tx_start), 32'd1);
    waitIdle("drain_single", 200);

    // Pointer now 1: serve requester 1 to move it to 2, then 0 and 1 together.
    applyStimulus(1, 8'h21);
    waitIdle("drain_ptr_setup", 200);
    grant_log.delete();
    @(negedge clk);
    applyStimulus(0, 8'h30);
    applyStimulus(1, 8'h31);
    waitIdle("drain_wrap", 400);
    exp_q = '{0, 1};
    checkLog("wrap_order", exp_q);

    // Pointer now 2: serving 3 wraps it to 0 for the all-valid round.
    applyStimulus(3, 8'h33);
    waitIdle("drain_ptr_reset", 200);
    grant_log.delete();
    @(negedge clk);
    for (int i = 0; i < N; i++) applyStimulus(i, 8'h10 + 8'(i));
    applyStimulus(0, 8'h10);
    waitIdle("drain_all_valid", 1000);
    exp_q = '{0, 1, 2, 3, 0};
    checkLog("rr_order", exp_q);

    // Transmitter busy before launch: nothing may start until it drops.
    stuck = 1'b1;
    @(negedge clk);
    starts0 = tx_start_count;
    applyStimulus(2, 8'h77);
    repeat (12) @(negedge clk);
    stuck_starts = tx_start_count - starts0;
    checkOutput("no_start_while_stuck", 32'(stuck_starts), 32'd0);
    stuck = 1'b0;
    waitIdle("drain_stuck", 300);
    checkOutput("stuck_start_pulses", 32'(tx_start_count - starts0),
                HDR_EN ? 32'd2 : 32'd1);

    // Requester 3, 8'hC3: header mode adds one 8'hA3 frame.
    starts0  = tx_start_count;
    readies0 = ready_count;
    applyStimulus(3, 8'hC3);
    waitIdle("drain_hdr", 300);
    checkOutput("hdr_start_pulses", 32'(tx_start_count - starts0),
                HDR_EN ? 32'd2 : 32'd1);
    checkOutput("hdr_ready_pulses", 32'(ready_count - readies0), 32'd1);

    // Randomized traffic against the scoreboard.
    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      mask = $urandom_range(1, 15);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) applyStimulus(i, 8'($urandom));
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    waitIdle("drain_random", 20000);

    // Reset in WAIT_LO: outputs clear, pointer restarts at requester 0.
    applyStimulus(1, 8'h99);
    starts0 = tx_start_count;
    waitTxStart(starts0, 200);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_ptr = 0;
    exp_data.delete();
    exp_id.delete();
    checkOutput("midreset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("midreset_tx_start", 32'(tx_start), 32'd0);
    checkOutput("midreset_tx_data", 32'(tx_data), 32'h00);
    checkOutput("midreset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("midreset_arb_busy", 32'(arb_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postreset_arb_busy", 32'(arb_busy), 32'd0);
    checkOutput("postreset_tx_data", 32'(tx_data), 32'h00);
    grant_log.delete();
    applyStimulus(0, 8'hA0);
    applyStimulus(2, 8'hA2);
    waitIdle("drain_post_reset", 400);
    exp_q = '{0, 2};
    checkLog("post_reset_order", exp_q);

    checkOutput("scoreboard_empty", 32'(exp_data.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
